// File: rtl/cond_pkg.sv
// Shared constants for the condition/status unit.
// Condition codes, NZCV flag positions and the flag merge helper.
package cond_pkg;

  localparam int NZCV_W = 4;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [NZCV_W-1:0] merge_flags(
    input logic [NZCV_W-1:0] old_f,
    input logic [NZCV_W-1:0] new_f,
    input logic [NZCV_W-1:0] mask
  );
    return (old_f & ~mask) | (new_f & mask);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Single-lane condition evaluator.
// Pure combinational lookup of the 4-bit condition against NZCV.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_status_unit.sv
// Banked NZCV status plus multi-lane execute/squash decision.
// One-cycle registered decision, optional same-cycle flag forwarding.
module cond_status_unit
  import cond_pkg::*;
#(
  parameter int LANES = 1,
  parameter int CTX = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W = 16,
  localparam int CTX_W = (CTX > 1) ? $clog2(CTX) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  input  logic [4*LANES-1:0] in_cond,
  input  logic [CTX_W-1:0]   in_ctx,
  input  logic               flag_we,
  input  logic [CTX_W-1:0]   flag_ctx,
  input  logic [3:0]         flag_mask,
  input  logic [3:0]         flag_in,
  output logic               out_valid,
  output logic [LANES-1:0]   out_exec,
  output logic [3:0]         status_out,
  output logic [CNT_W-1:0]   fail_count
);

  localparam int FW = $clog2(LANES + 1);

  logic [NZCV_W-1:0] bank [CTX];
  logic              wr_ok;
  logic              rd_ok;
  logic              bypass;
  logic [NZCV_W-1:0] stored;
  logic [NZCV_W-1:0] eval_f;
  logic [LANES-1:0]  pass;
  logic [FW-1:0]     fails;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  cnt_next;

  assign wr_ok = 32'(flag_ctx) < CTX;
  assign rd_ok = 32'(in_ctx) < CTX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CTX; i++) begin
        bank[i] <= '0;
      end
    end else if (flag_we && wr_ok) begin
      bank[flag_ctx] <= merge_flags(bank[flag_ctx], flag_in, flag_mask);
    end
  end

  assign stored = rd_ok ? bank[in_ctx] : '0;
  assign status_out = stored;

  // Out-of-range banks never forward: they always read as zero.
  assign bypass = (BYPASS != 0) && flag_we && wr_ok && rd_ok
                  && (flag_ctx == in_ctx);
  assign eval_f = bypass ? merge_flags(stored, flag_in, flag_mask)
                         : stored;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    cond_eval u_eval (
      .cond (in_cond[4*i +: 4]),
      .nzcv (eval_f),
      .pass (pass[i])
    );
  end

  always_comb begin
    fails = '0;
    for (int i = 0; i < LANES; i++) begin
      if (!pass[i]) fails = fails + 1'b1;
    end
  end

  assign sum = {1'b0, fail_count} + (CNT_W + 1)'(fails);
  assign cnt_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_exec   <= '0;
      fail_count <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_exec  <= '0;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_exec  <= in_valid ? pass : '0;
      if (in_valid) fail_count <= cnt_next;
    end
  end

endmodule
